// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared CLIC arbiter types and constants
package ariane_pkg;

   localparam int ClicLvlWidth = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      CLR  = 2'd2
   } clic_arb_state_e;

endpackage

// File: rtl/clic_irq_arbiter_if.sv
// rtl/clic_irq_arbiter_if.sv - arbiter-to-decoder request/ack/clear handshake
interface clic_irq_arbiter_if
   import ariane_pkg::*;
#(
   parameter int NumSrc   = 64,
   parameter int LvlWidth = ClicLvlWidth
) ();

   logic [NumSrc-1:0]   irq_o;
   logic [LvlWidth-1:0] irq_level_o;
   logic                irq_ack_i;
   logic [NumSrc-1:0]   clr_o;

   modport master (output irq_o, output irq_level_o, output clr_o, input irq_ack_i);
   modport slave  (input irq_o, input irq_level_o, input clr_o, output irq_ack_i);

endinterface

// File: rtl/clic_max_tree.sv
// rtl/clic_max_tree.sv - combinational max-level compare tree, ties go to the higher index
module clic_max_tree
   import ariane_pkg::*;
#(
   parameter int NumSrc   = 64,
   parameter int LvlWidth = ClicLvlWidth,
   parameter int IdW      = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
   input  logic [NumSrc-1:0]          valid_i,
   input  logic [NumSrc*LvlWidth-1:0] level_i,
   output logic                       valid_o,
   output logic [IdW-1:0]             id_o,
   output logic [LvlWidth-1:0]        level_o
);

   localparam int P = 1 << IdW;

   logic [P-1:0]          v_pad;
   logic [P*LvlWidth-1:0] l_pad;
   logic                  node_v  [2*P-1];
   logic [LvlWidth-1:0]   node_l  [2*P-1];
   logic [IdW-1:0]        node_id [2*P-1];

   assign v_pad = P'(valid_i);
   assign l_pad = (P*LvlWidth)'(level_i);

   // Heap layout: leaves at P-1.., node k has children 2k+1 (lower ids) and 2k+2 (higher ids).
   always_comb begin
      for (int k = 0; k < 2*P-1; k++) begin
         node_v[k]  = 1'b0;
         node_l[k]  = '0;
         node_id[k] = '0;
      end
      for (int i = 0; i < P; i++) begin
         node_v[P-1+i]  = v_pad[i];
         node_l[P-1+i]  = l_pad[i*LvlWidth +: LvlWidth];
         node_id[P-1+i] = IdW'(i);
      end
      for (int k = P-2; k >= 0; k--) begin
         if (node_v[2*k+2] && (!node_v[2*k+1] || node_l[2*k+2] >= node_l[2*k+1])) begin
            node_v[k]  = 1'b1;
            node_l[k]  = node_l[2*k+2];
            node_id[k] = node_id[2*k+2];
         end else begin
            node_v[k]  = node_v[2*k+1];
            node_l[k]  = node_l[2*k+1];
            node_id[k] = node_id[2*k+1];
         end
      end
   end

   assign valid_o = node_v[0];
   assign id_o    = node_id[0];
   assign level_o = node_l[0];

endmodule

// File: rtl/clic_irq_arbiter.sv
// rtl/clic_irq_arbiter.sv - CLIC request arbiter FSM; CLIC_ARB_PREEMPT_EN enables preemption
module clic_irq_arbiter
   import ariane_pkg::*;
#(
   parameter int NumSrc   = 64,
   parameter int LvlWidth = ClicLvlWidth
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NumSrc-1:0]          pend_i,
   input  logic [NumSrc-1:0]          ie_i,
   input  logic [NumSrc*LvlWidth-1:0] level_i,
   input  logic [LvlWidth-1:0]        thresh_i,
   input  logic                       mie_i,
   clic_irq_arbiter_if.master         core
);

   localparam int IdW = (NumSrc > 1) ? $clog2(NumSrc) : 1;

`ifdef CLIC_ARB_PREEMPT_EN
   localparam bit PreemptEn = 1'b1;
`else
   localparam bit PreemptEn = 1'b0;
`endif

   clic_arb_state_e     state;
   logic [IdW-1:0]      held_id;
   logic [LvlWidth-1:0] held_lvl;
   logic [NumSrc-1:0]   irq_q;
   logic [NumSrc-1:0]   clr_q;

   logic [NumSrc-1:0]   elig;
   logic                win_valid;
   logic [IdW-1:0]      win_id;
   logic [LvlWidth-1:0] win_lvl;
   logic                held_elig;
   logic                preempt;

   function automatic logic [NumSrc-1:0] onehot(input logic [IdW-1:0] id);
      return NumSrc'(1) << id;
   endfunction

   // Level 0 can never win: the compare is strict against an unsigned threshold.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NumSrc; i++) begin
         elig[i] = pend_i[i] & ie_i[i] & mie_i &
                   (level_i[i*LvlWidth +: LvlWidth] > thresh_i);
      end
   end

   clic_max_tree #(
      .NumSrc   (NumSrc),
      .LvlWidth (LvlWidth),
      .IdW      (IdW)
   ) u_tree (
      .valid_i (elig),
      .level_i (level_i),
      .valid_o (win_valid),
      .id_o    (win_id),
      .level_o (win_lvl)
   );

   assign held_elig = elig[held_id];
   assign preempt   = PreemptEn && win_valid && (win_lvl > held_lvl);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         held_id  <= '0;
         held_lvl <= '0;
         irq_q    <= '0;
         clr_q    <= '0;
      end else begin
         clr_q <= '0;
         unique case (state)
            IDLE: begin
               if (win_valid) begin
                  state    <= REQ;
                  held_id  <= win_id;
                  held_lvl <= win_lvl;
                  irq_q    <= onehot(win_id);
               end
            end
            REQ: begin
               // Ack outranks withdrawal and preemption in the same cycle.
               if (core.irq_ack_i) begin
                  state    <= CLR;
                  clr_q    <= onehot(held_id);
                  irq_q    <= '0;
                  held_id  <= '0;
                  held_lvl <= '0;
               end else if (!held_elig) begin
                  state    <= IDLE;
                  irq_q    <= '0;
                  held_id  <= '0;
                  held_lvl <= '0;
               end else if (preempt) begin
                  held_id  <= win_id;
                  held_lvl <= win_lvl;
                  irq_q    <= onehot(win_id);
               end
            end
            CLR: begin
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               irq_q    <= '0;
               held_id  <= '0;
               held_lvl <= '0;
            end
         endcase
      end
   end

   assign core.irq_o       = irq_q;
   assign core.irq_level_o = held_lvl;
   assign core.clr_o       = clr_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// tb/tb_clic_irq_arbiter.sv - self-checking bench for clic_irq_arbiter (honours CLIC_ARB_PREEMPT_EN)
module tb_clic_irq_arbiter;

   localparam int N = 64;
   localparam int W = 8;

`ifdef CLIC_ARB_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   pend = '0;
   logic [N-1:0]   ie = '0;
   logic [N*W-1:0] level = '0;
   logic [W-1:0]   thresh = '0;
   logic           mie = 1'b0;
   bit             chk_en = 1'b0;
   int             n_vec = 0;
   int             n_err = 0;

   clic_irq_arbiter_if #(.NumSrc(N), .LvlWidth(W)) core_if ();

   clic_irq_arbiter #(.NumSrc(N), .LvlWidth(W)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .pend_i   (pend),
      .ie_i     (ie),
      .level_i  (level),
      .thresh_i (thresh),
      .mie_i    (mie),
      .core     (core_if.master)
   );

   always #5 clk = ~clk;

   // Reference model: who is requesting, and which id is being cleared this cycle.
   int         m_hold = -1;
   int         m_clr  = -1;
   logic [7:0] m_lvl  = '0;

   function automatic logic [7:0] lvl_of(int i);
      return level[i*W +: W];
   endfunction

   function automatic bit elig(int i);
      return pend[i] && ie[i] && mie && (lvl_of(i) > thresh);
   endfunction

   function automatic int win();
      int b = -1;
      for (int i = 0; i < N; i++)
         if (elig(i) && (b < 0 || lvl_of(i) >= lvl_of(b))) b = i;
      return b;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_hold <= -1; m_clr <= -1; m_lvl <= '0;
      end else if (m_clr >= 0) begin
         m_clr <= -1;
      end else if (m_hold >= 0) begin
         if (core_if.irq_ack_i) begin
            m_clr <= m_hold; m_hold <= -1; m_lvl <= '0;
         end else if (!elig(m_hold)) begin
            m_hold <= -1; m_lvl <= '0;
         end else if (PREEMPT && win() >= 0 && lvl_of(win()) > m_lvl) begin
            m_hold <= win(); m_lvl <= lvl_of(win());
         end
      end else if (win() >= 0) begin
         m_hold <= win(); m_lvl <= lvl_of(win());
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [N-1:0] e_irq, e_clr;
         logic [W-1:0] e_lvl;
         e_irq = (m_hold >= 0) ? (64'd1 << m_hold) : '0;
         e_clr = (m_clr >= 0) ? (64'd1 << m_clr) : '0;
         e_lvl = (m_hold >= 0) ? m_lvl : '0;
         n_vec++;
         if (core_if.irq_o !== e_irq || core_if.irq_level_o !== e_lvl ||
             core_if.clr_o !== e_clr || !$onehot0(core_if.irq_o)) begin
            n_err++;
            $display("FAIL model t=%0t: irq_o=%h lvl=%0d clr_o=%h, required irq_o=%h lvl=%0d clr_o=%h",
                     $time, core_if.irq_o, core_if.irq_level_o, core_if.clr_o, e_irq, e_lvl, e_clr);
         end
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic lit(input string name, input logic [N-1:0] e_irq,
                      input logic [W-1:0] e_lvl, input logic [N-1:0] e_clr);
      @(negedge clk);
      n_vec++;
      if (core_if.irq_o !== e_irq || core_if.irq_level_o !== e_lvl || core_if.clr_o !== e_clr) begin
         n_err++;
         $display("FAIL %s: irq_o=%h lvl=%0d clr_o=%h, required irq_o=%h lvl=%0d clr_o=%h",
                  name, core_if.irq_o, core_if.irq_level_o, core_if.clr_o, e_irq, e_lvl, e_clr);
      end
   endtask

   task automatic set_src(input int i, input bit p, input bit e, input logic [7:0] l);
      pend[i] = p; ie[i] = e; level[i*W +: W] = l;
   endtask

   task automatic clear_all();
      pend = '0; ie = '0; level = '0;
   endtask

   initial begin
      core_if.irq_ack_i = 1'b0;
      step(); step();
      chk_en = 1'b1;
      lit("reset", '0, 8'd0, '0);
      rst = 1'b0; thresh = 8'd3; mie = 1'b1;

      set_src(5, 1, 1, 8'd10);
      step(); lit("first_req", 64'd1 << 5, 8'd10, '0);

      core_if.irq_ack_i = 1'b1; step(); core_if.irq_ack_i = 1'b0;
      lit("ack_t1", '0, 8'd0, 64'd1 << 5);
      step(); lit("ack_t2", '0, 8'd0, '0);
      step(); lit("ack_t3", 64'd1 << 5, 8'd10, '0);

      thresh = 8'd10;
      step(); lit("withdraw", '0, 8'd0, '0);
      step(); lit("withdraw_hold", '0, 8'd0, '0);

      clear_all(); thresh = 8'd3;
      set_src(3, 1, 1, 8'd20); set_src(9, 1, 1, 8'd20);
      step(); lit("tie_high_idx", 64'd1 << 9, 8'd20, '0);
      pend = '0;
      step(); lit("tie_drop", '0, 8'd0, '0);
      set_src(3, 1, 1, 8'd21); set_src(9, 1, 1, 8'd20);
      step(); lit("max_level", 64'd1 << 3, 8'd21, '0);

      clear_all();
      step(); lit("idle_again", '0, 8'd0, '0);
      set_src(5, 1, 1, 8'd10);
      step(); lit("hold5", 64'd1 << 5, 8'd10, '0);
      set_src(7, 1, 1, 8'd50);
      step();
      if (PREEMPT) lit("preempt", 64'd1 << 7, 8'd50, '0);
      else         lit("no_preempt", 64'd1 << 5, 8'd10, '0);
      clear_all();
      step(); lit("drop_all", '0, 8'd0, '0);
      set_src(5, 1, 1, 8'd10);
      step(); lit("hold5_b", 64'd1 << 5, 8'd10, '0);
      set_src(7, 1, 1, 8'd50); core_if.irq_ack_i = 1'b1;
      step(); core_if.irq_ack_i = 1'b0;
      lit("ack_beats_preempt", '0, 8'd0, 64'd1 << 5);
      step(); lit("after_clr", '0, 8'd0, '0);
      step(); lit("next_win7", 64'd1 << 7, 8'd50, '0);

      core_if.irq_ack_i = 1'b1; step(); core_if.irq_ack_i = 1'b0;
      lit("in_clr7", '0, 8'd0, 64'd1 << 7);
      rst = 1'b1; step(); rst = 1'b0;
      lit("rst_in_clr", '0, 8'd0, '0);
      step(); lit("idle_after_rst", 64'd1 << 7, 8'd50, '0);
      core_if.irq_ack_i = 1'b1; rst = 1'b1;
      step(); core_if.irq_ack_i = 1'b0; rst = 1'b0;
      lit("rst_suppresses_clr", '0, 8'd0, '0);
      step(); lit("req_after_rst", 64'd1 << 7, 8'd50, '0);

      clear_all(); mie = 1'b0;
      step(); lit("drop7", '0, 8'd0, '0);
      set_src(2, 1, 1, 8'd30); core_if.irq_ack_i = 1'b1;
      step(); core_if.irq_ack_i = 1'b0;
      lit("mie_off_ack_idle", '0, 8'd0, '0);
      mie = 1'b1; thresh = 8'd0; set_src(2, 1, 1, 8'd0);
      step(); lit("level0", '0, 8'd0, '0);
      set_src(2, 1, 1, 8'd1);
      step(); lit("level1_thresh0", 64'd1 << 2, 8'd1, '0);
      clear_all();
      step(); lit("drop2", '0, 8'd0, '0);
      thresh = 8'd200; set_src(40, 1, 1, 8'd201); set_src(41, 1, 1, 8'd200);
      step(); lit("unsigned_cmp", 64'd1 << 40, 8'd201, '0);

      clear_all(); thresh = 8'd2;
      for (int c = 0; c < 200; c++) begin
         for (int s = 0; s < 8; s++) begin
            pend[s] = ($urandom_range(0, 2) != 0);
            ie[s]   = ($urandom_range(0, 5) != 0);
            if (c % 10 == 0) level[s*W +: W] = 8'($urandom_range(0, 12));
         end
         thresh = 8'($urandom_range(0, 4));
         mie = ($urandom_range(0, 15) != 0);
         core_if.irq_ack_i = ($urandom_range(0, 3) == 0);
         step();
      end
      core_if.irq_ack_i = 1'b0;
      step(); step();
      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/clic_irq_arbiter.md
CLIC_IRQ_ARBITER -- requirements
Module: clic_irq_arbiter

Interface
REQ-001 SHALL have parameter NumSrc, default 64, number of interrupt sources (matches ariane_soc::NumInterruptSrc).
REQ-002 SHALL have parameter LvlWidth, default 8, interrupt level width.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port pend_i  in  NumSrc  per-source pending.
REQ-006 SHALL have port ie_i  in  NumSrc  per-source enable.
REQ-007 SHALL have port level_i  in  NumSrc*LvlWidth  per-source level, packed; source i at bits [i*LvlWidth +: LvlWidth].
REQ-008 SHALL have port thresh_i  in  LvlWidth  effective threshold, max(mintthresh, mintstatus.mil).
REQ-009 SHALL have port mie_i  in  1  global machine interrupt enable.
REQ-010 SHALL have port irq_o  out  NumSrc  one-hot or zero request to decode.
REQ-011 SHALL have port irq_level_o  out  LvlWidth  level of the source on irq_o; 0 when irq_o=0.
REQ-012 SHALL have port irq_ack_i  in  1  core handshake, from decoder irq_ack_o.
REQ-013 SHALL have port clr_o  out  NumSrc  one-cycle one-hot pulse clearing the acked source's pending bit.

Function
REQ-014 SHALL define eligible(i) as pend_i[i] & ie_i[i] & (level_i[i] > thresh_i) & mie_i.
REQ-015 SHALL select the winner combinationally: the eligible source with maximum level; on equal levels the higher index wins.
REQ-016 SHALL implement the FSM states IDLE, REQ and CLR.
REQ-017 SHALL, in IDLE with any eligible source at cycle t, register the winner id and level and enter REQ; irq_o SHALL be one-hot at t+1.
REQ-018 SHALL, in REQ, hold irq_o and irq_level_o stable except when REQ-020 or REQ-021 applies.
REQ-019 SHALL, in REQ with irq_ack_i=1 at cycle t, enter CLR: irq_o=0 at t+1, clr_o one-hot for the held id at t+1 only, then IDLE at t+2; the earliest new irq_o is at t+3.
REQ-020 SHALL, in REQ with irq_ack_i=0 and the held source no longer eligible, return to IDLE with irq_o=0 next cycle and no clr_o (withdrawal).
REQ-021 SHALL give irq_ack_i priority over withdrawal and preemption when they occur in the same cycle.
REQ-022 SHALL ignore irq_ack_i in IDLE and CLR.
REQ-023 SHALL keep irq_o $onehot0 in every cycle; clr_o SHALL be nonzero only in CLR.
REQ-024 SHALL compare levels unsigned at full LvlWidth; level 0 is never eligible.

Reset
REQ-025 SHALL, while rst_i=1 at a clock edge, enter IDLE and clear the held id/level, so that irq_o=0, irq_level_o=0 and clr_o=0 from the next cycle.
REQ-026 SHALL, on reset mid-REQ or mid-CLR, drop the request and suppress any pending clr_o pulse.

Configuration
REQ-027 SHALL support the macro CLIC_ARB_PREEMPT_EN; when defined, in REQ without ack, an eligible winner with strictly higher level than the held level SHALL replace the held id/level on the next cycle (still one-hot, no clr_o).
REQ-028 SHALL, without CLIC_ARB_PREEMPT_EN, keep the held request until ack or withdrawal regardless of higher-level arrivals.

Structure
REQ-029 SHALL place clic_arb_state_e (IDLE, REQ, CLR) and the constant ClicLvlWidth=8 in ariane_pkg.
REQ-030 SHALL implement winner selection in a sub-module clic_max_tree: a log2(NumSrc)-depth binary compare tree outputting valid, id and level; purely combinational.

Verification
REQ-031 SHALL verify: src 5 pend, ie=1, level 10, thresh 3, mie=1 at cycle 0 -> irq_o=1<<5 and irq_level_o=10 at cycle 1.
REQ-032 SHALL verify: src 3 lvl 20 and src 9 lvl 20 both eligible -> irq_o=1<<9; src 3 lvl 21 -> irq_o=1<<3.
REQ-033 SHALL verify: ack at cycle t while holding src 5 -> irq_o=0 and clr_o=1<<5 at t+1, clr_o=0 at t+2, src 5 still pending yields a new request at t+3.
REQ-034 SHALL verify: holding src 5 lvl 10, thresh raised to 10 without ack -> irq_o=0 next cycle and clr_o never asserted.
REQ-035 SHALL verify: holding src 5 lvl 10, src 7 lvl 50 arrives -> with CLIC_ARB_PREEMPT_EN irq_o=1<<7 next cycle; without it irq_o stays 1<<5; with ack in the same cycle -> clr_o=1<<5 in both builds.
REQ-036 SHALL verify: rst_i=1 asserted in CLR -> clr_o=0 and irq_o=0 next cycle, FSM in IDLE.
